uart_frame_ctrl: RTL and testbench

- Sequences the byte stream from uart_receiver into framed register-write commands.
- Hunts for a sync byte, then collects address, length, payload and checksum.
- On a good checksum, buffered payload is replayed as one register write per cycle.
- Sits between uart_receiver (o_data / o_ready_to_read) and the board register file; reports frame success/failure for debug LEDs.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_frame_ctrl_if.sv | 23 ++
 rtl/uart_frame_buffer.sv | 23 ++
 rtl/uart_frame_ctrl.sv | 177 +++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-controller state/error enums, sync marker and
// bit-timing constants used by both the receiver and the frame controller.
package uart_pkg;

  localparam int         FULL_BIT      = 21812;
  localparam int         HALF_BIT      = FULL_BIT / 2;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BAD_LEN  = 2'd1,
    ERR_BAD_CSUM = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_t;

endpackage

// File: rtl/uart_frame_ctrl_if.sv
// Byte-in / register-write-out bundle between uart_receiver, the frame
// controller and the board register file.
interface uart_frame_ctrl_if;
  logic [7:0] i_byte;
  logic       i_byte_valid;
  logic       o_wr_en;
  logic [7:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_frame_ok;
  logic       o_frame_err;
  logic [1:0] o_err_code;
  logic       o_busy;

  modport slave (
    input  i_byte, i_byte_valid,
    output o_wr_en, o_wr_addr, o_wr_data, o_frame_ok, o_frame_err, o_err_code, o_busy
  );

  modport master (
    output i_byte, i_byte_valid,
    input  o_wr_en, o_wr_addr, o_wr_data, o_frame_ok, o_frame_err, o_err_code, o_busy
  );
endinterface

// File: rtl/uart_frame_buffer.sv
// Payload store for one frame: MAX_LEN bytes, indexed write and async indexed read.
module uart_frame_buffer #(
  parameter int MAX_LEN = 8,
  parameter int AW      = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  // Contents are only read after being written in the same frame, so no reset.
  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_ctrl.sv
// Hunts for SYNC, collects ADDR/LEN/payload/CSUM, and on a good checksum replays
// the buffered payload as one register write per cycle.
module uart_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         MAX_LEN        = 8,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             i_reset,
  uart_frame_ctrl_if.slave bus
);

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_n;
  logic [7:0]    addr_q, addr_n;
  logic [IW-1:0] len_q, len_n;
  logic [IW-1:0] idx_q, idx_n;
  logic [7:0]    csum_q, csum_n;
  logic [TW-1:0] tmo_q, tmo_n;
  logic          wr_en_q, wr_en_n;
  logic [7:0]    wr_addr_q, wr_addr_n;
  logic [7:0]    wr_data_q, wr_data_n;
  logic          ok_q, ok_n;
  logic          err_q, err_n;
  err_t          code_q, code_n;

  logic          buf_we;
  logic [IW-1:0] rd_idx;
  logic [7:0]    rd_data;
  logic          in_frame;
  logic          bv;
  logic [7:0]    b;

  assign bv = bus.i_byte_valid;
  assign b  = bus.i_byte;

  uart_frame_buffer #(.MAX_LEN(MAX_LEN), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx_q[AW-1:0]),
    .wdata (b),
    .raddr (rd_idx[AW-1:0]),
    .rdata (rd_data)
  );

  always_comb begin
    state_n   = state_q;
    addr_n    = addr_q;
    len_n     = len_q;
    idx_n     = idx_q;
    csum_n    = csum_q;
    tmo_n     = '0;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr_q;
    wr_data_n = wr_data_q;
    ok_n      = 1'b0;
    err_n     = 1'b0;
    code_n    = code_q;
    buf_we    = 1'b0;
    rd_idx    = idx_q;
    in_frame  = (state_q == ST_ADDR) || (state_q == ST_LEN) ||
                (state_q == ST_PAYLOAD) || (state_q == ST_CSUM);

    if (in_frame && !bv) tmo_n = tmo_q + TW'(1);

    case (state_q)
      ST_IDLE: if (bv && b == SYNC_BYTE) state_n = ST_ADDR;
      ST_ADDR: if (bv) begin
        addr_n  = b;
        csum_n  = b;
        state_n = ST_LEN;
      end
      ST_LEN: if (bv) begin
        if (b == 8'd0 || b > 8'(MAX_LEN)) begin
          err_n   = 1'b1;
          code_n  = ERR_BAD_LEN;
          state_n = ST_IDLE;
        end else begin
          len_n   = b[IW-1:0];
          csum_n  = csum_q ^ b;
          idx_n   = '0;
          state_n = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: if (bv) begin
        buf_we = 1'b1;
        csum_n = csum_q ^ b;
        idx_n  = idx_q + IW'(1);
        if (idx_n == len_q) state_n = ST_CSUM;
      end
      ST_CSUM: begin
        // Pre-load write 0 so the first write lands the cycle after CSUM.
        rd_idx = '0;
        if (bv) begin
          if (b == csum_q) begin
            state_n   = ST_DRAIN;
            idx_n     = IW'(1);
            wr_en_n   = 1'b1;
            wr_addr_n = addr_q;
            wr_data_n = rd_data;
            ok_n      = (len_q == IW'(1));
          end else begin
            err_n   = 1'b1;
            code_n  = ERR_BAD_CSUM;
            state_n = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (idx_q == len_q) begin
          state_n = ST_IDLE;
          idx_n   = '0;
        end else begin
          wr_en_n   = 1'b1;
          wr_addr_n = addr_q + 8'(idx_q);
          wr_data_n = rd_data;
          idx_n     = idx_q + IW'(1);
          ok_n      = (idx_n == len_q);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A byte in the firing cycle keeps the frame alive.
    if (in_frame && !bv && tmo_q == TMO_LAST) begin
      err_n   = 1'b1;
      code_n  = ERR_TIMEOUT;
      state_n = ST_IDLE;
      tmo_n   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
      tmo_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
    end else begin
      state_q   <= state_n;
      addr_q    <= addr_n;
      len_q     <= len_n;
      idx_q     <= idx_n;
      csum_q    <= csum_n;
      tmo_q     <= tmo_n;
      wr_en_q   <= wr_en_n;
      wr_addr_q <= wr_addr_n;
      wr_data_q <= wr_data_n;
      ok_q      <= ok_n;
      err_q     <= err_n;
      code_q    <= code_n;
    end
  end

  assign bus.o_wr_en     = wr_en_q;
  assign bus.o_wr_addr   = wr_addr_q;
  assign bus.o_wr_data   = wr_data_q;
  assign bus.o_frame_ok  = ok_q;
  assign bus.o_frame_err = err_q;
  assign bus.o_err_code  = code_q;
  assign bus.o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Scoreboard bench for uart_frame_ctrl: stimulus pushes expected writes/errors
// with their cycle; a negedge monitor pops and compares whatever the DUT emits.
module tb_uart_frame_ctrl;
  localparam int MAXL = 8;
  localparam int TMO  = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_frame_ctrl_if bif();

  uart_frame_ctrl #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAXL), .TIMEOUT_CYCLES(TMO)) dut (
    .clk     (clk),
    .i_reset (rst),
    .bus     (bif.slave)
  );

  typedef struct {
    int         cyc;
    bit         is_err;
    logic [7:0] a;
    logic [7:0] d;
    bit         ok;
    logic [1:0] code;
  } exp_t;

  exp_t       expq[$];
  exp_t       me;
  logic [7:0] pl[$];
  int         cyc  = 0;
  int         nvec = 0;
  int         nmis = 0;
  int         last = 0;
  bit         mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h (cyc %0d)", nm, act, want, cyc);
    end
  endtask

  // Monitor: every output event must match the head of the queue in the same cycle.
  always @(negedge clk) if (mon_en) begin
    while (expq.size() > 0 && expq[0].cyc < cyc) begin
      nvec++; nmis++;
      $display("FAIL missing_event: expected %s at cyc %0d, absent (now %0d)",
               expq[0].is_err ? "error" : "write", expq[0].cyc, cyc);
      void'(expq.pop_front());
    end
    if (bif.o_wr_en || bif.o_frame_ok || bif.o_frame_err) begin
      if (expq.size() == 0 || expq[0].cyc != cyc) begin
        nvec++; nmis++;
        $display("FAIL unexpected_event: wr_en=%b addr=%h data=%h ok=%b err=%b code=%0d at cyc %0d, want none",
                 bif.o_wr_en, bif.o_wr_addr, bif.o_wr_data, bif.o_frame_ok,
                 bif.o_frame_err, bif.o_err_code, cyc);
      end else begin
        me = expq.pop_front();
        if (me.is_err)
          chk("err_event", 32'({bif.o_wr_en, bif.o_frame_ok, bif.o_frame_err, bif.o_err_code}),
              32'({1'b0, 1'b0, 1'b1, me.code}));
        else
          chk("write_event", 32'({bif.o_wr_en, bif.o_frame_ok, bif.o_frame_err, bif.o_wr_addr, bif.o_wr_data}),
              32'({1'b1, me.ok, 1'b0, me.a, me.d}));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic put(input logic [7:0] b);
    bif.i_byte       = b;
    bif.i_byte_valid = 1'b1;
    last = cyc;
    tick();
    bif.i_byte_valid = 1'b0;
  endtask

  task automatic exp_err(input int c, input logic [1:0] code);
    exp_t e;
    e.cyc = c; e.is_err = 1'b1; e.a = '0; e.d = '0; e.ok = 1'b0; e.code = code;
    expq.push_back(e);
  endtask

  // Sends SYNC/ADDR/LEN/pl/CSUM; cflip != 0 corrupts the checksum.
  task automatic send_frame(input logic [7:0] addr, input logic [7:0] cflip,
                            input int gap, input bit settle);
    logic [7:0] len, cs;
    exp_t e;
    len = 8'(pl.size());
    cs  = addr ^ len;
    foreach (pl[i]) cs ^= pl[i];
    put(8'hA5);
    put(addr);
    idle(gap);
    put(len);
    foreach (pl[i]) put(pl[i]);
    put(cs ^ cflip);
    if (cflip == 8'h00) begin
      foreach (pl[i]) begin
        e.cyc = last + 1 + i; e.is_err = 1'b0;
        e.a = addr + 8'(i); e.d = pl[i];
        e.ok = (i == pl.size() - 1); e.code = '0;
        expq.push_back(e);
      end
    end else begin
      exp_err(last + 1, 2'd2);
    end
    if (settle) idle(pl.size() + 1);
  endtask

  task automatic send_badlen(input logic [7:0] addr, input logic [7:0] len);
    put(8'hA5); put(addr); put(len);
    exp_err(last + 1, 2'd1);
    idle(2);
  endtask

  task automatic flush_after(input int c);
    exp_t kept[$];
    foreach (expq[i]) if (expq[i].cyc <= c) kept.push_back(expq[i]);
    expq = kept;
  endtask

  task automatic rand_payload(input int len);
    pl = {};
    for (int i = 0; i < len; i++)
      pl.push_back(($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom));
  endtask

  initial begin
    #1_000_000;
    nmis++;
    $display("FAIL watchdog: bench did not finish within time limit");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    logic [7:0] fr[$];
    int kind, m, len;
    bif.i_byte = 8'h00;
    bif.i_byte_valid = 1'b0;
    rst = 1'b1;
    idle(3);
    @(negedge clk);
    chk("reset_state", 32'({bif.o_wr_en, bif.o_frame_ok, bif.o_frame_err, bif.o_err_code,
                            bif.o_busy, bif.o_wr_addr, bif.o_wr_data}), 32'h0);
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Good frame A5 10 03 11 22 33 13
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h10, 8'h00, 0, 1'b1);
    @(negedge clk);
    chk("busy_after_good", 32'(bif.o_busy), 32'h0);

    // Bad checksum (14 instead of 13), then a good frame
    send_frame(8'h10, 8'h07, 0, 1'b1);
    send_frame(8'h10, 8'h00, 0, 1'b1);

    // Bad lengths
    send_badlen(8'h20, 8'h00);
    send_badlen(8'h20, 8'(MAXL + 1));

    // Timeout mid-payload, then address wrap
    put(8'hA5); put(8'hFF); put(8'h02); put(8'hAA);
    exp_err(last + TMO + 1, 2'd3);
    idle(TMO + 3);
    @(negedge clk);
    chk("err_code_held", 32'({bif.o_err_code, bif.o_busy}), 32'({2'd3, 1'b0}));
    pl = '{8'hAA, 8'hBB};
    send_frame(8'hFF, 8'h00, 0, 1'b1);

    // Byte arriving exactly when the timeout would fire keeps the frame
    pl = '{8'h5C, 8'h6D};
    send_frame(8'h30, 8'h00, TMO - 1, 1'b1);

    // Noise in IDLE and SYNC value inside payload
    put(8'h00); put(8'h7E);
    pl = '{8'hA5};
    send_frame(8'h05, 8'h00, 0, 1'b1);

    // Reset during PAYLOAD
    put(8'hA5); put(8'h10); put(8'h03); put(8'h11);
    @(negedge clk);
    chk("busy_mid_frame", 32'(bif.o_busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("after_reset_payload", 32'({bif.o_busy, bif.o_wr_en, bif.o_frame_ok, bif.o_frame_err}), 32'h0);
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h10, 8'h00, 0, 1'b1);

    // Reset during DRAIN, right after the first write appears
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h40, 8'h00, 0, 1'b0);
    rst = 1'b1;
    flush_after(cyc);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("after_reset_drain", 32'({bif.o_busy, bif.o_wr_en, bif.o_frame_ok, bif.o_frame_err}), 32'h0);
    idle(4);
    pl = '{8'h01, 8'h02, 8'h03};
    send_frame(8'h50, 8'h00, 0, 1'b1);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, MAXL);
      if (kind <= 4) begin
        rand_payload(len);
        send_frame(8'($urandom), 8'h00, (kind == 4) ? $urandom_range(0, TMO - 1) : 0, 1'b1);
      end else if (kind == 5) begin
        rand_payload(len);
        send_frame(8'($urandom), 8'($urandom_range(1, 255)), 0, 1'b1);
      end else if (kind == 6) begin
        send_badlen(8'($urandom), ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXL + 1, 255)));
      end else if (kind == 7) begin
        repeat ($urandom_range(1, 3)) put(8'($urandom_range(0, 8'hA4)));
      end else if (kind == 8) begin
        rand_payload(len);
        fr = {};
        fr.push_back(8'hA5); fr.push_back(8'($urandom)); fr.push_back(8'(len));
        foreach (pl[i]) fr.push_back(pl[i]);
        m = $urandom_range(1, len + 3);
        for (int i = 0; i < m; i++) put(fr[i]);
        exp_err(last + TMO + 1, 2'd3);
        idle(TMO + 3);
      end else begin
        pl = {};
        for (int i = 0; i < len; i++) pl.push_back(8'hA5);
        send_frame(8'hFF - 8'($urandom_range(0, 3)), 8'h00, 0, 1'b1);
      end
    end

    idle(5);
    chk("queue_drained", 32'(expq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
